// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_stream_reader_pkg;

  localparam logic [2:0] BUF_DEPTH = 3'd2;

  // Words committed to the holding buffer once this cycle's downstream pop retires.
  function automatic logic [2:0] fill_after(input logic [1:0] occ,
                                            input logic       inflight,
                                            input logic       pop);
    fill_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// Pops words from the synchronous FIFO and presents them on a valid/ready stream,
// hiding the FIFO's one-cycle read latency behind a 2-entry holding buffer.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  output logic                   fifo_read,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [COUNT_WIDTH-1:0] words_out
);

  logic [1:0]             occ_r;
  logic [1:0]             occ_next_s;
  logic [1:0]             slot_s;
  logic                   inflight_r;
  logic                   drop_r;
  logic [DATA_WIDTH-1:0]  b0_r;
  logic [DATA_WIDTH-1:0]  b1_r;
  logic [DATA_WIDTH-1:0]  b0_next_s;
  logic [DATA_WIDTH-1:0]  b1_next_s;
  logic [COUNT_WIDTH-1:0] words_r;
  logic                   pop_s;
  logic                   push_s;
  logic                   read_s;

  // Pop/push decisions, read throttling and next buffer contents.
  always_comb begin
    pop_s      = (occ_r != 2'd0) & out_ready;
    push_s     = inflight_r & ~drop_r & ~flush;
    slot_s     = occ_r - {1'b0, pop_s};
    b0_next_s  = b0_r;
    b1_next_s  = b1_r;
    occ_next_s = slot_s + {1'b0, push_s};
    // A read is only issued if its word is guaranteed a free slot on arrival.
    if (!reset && !flush && !fifo_empty) begin
      read_s = (fill_after(occ_r, inflight_r, pop_s) < BUF_DEPTH);
    end else begin
      read_s = 1'b0;
    end
    if (pop_s) begin
      b0_next_s = b1_r;
    end else begin
      b0_next_s = b0_r;
    end
    if (push_s) begin
      case (slot_s)
        2'd0:    b0_next_s = fifo_read_data;
        2'd1:    b1_next_s = fifo_read_data;
        default: b1_next_s = b1_r;
      endcase
    end else begin
      b1_next_s = b1_next_s;
    end
    if (flush) begin
      occ_next_s = 2'd0;
    end else begin
      occ_next_s = occ_next_s;
    end
  end

  // Control state and delivered-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      drop_r     <= 1'b0;
      words_r    <= {COUNT_WIDTH{1'b0}};
    end else begin
      occ_r      <= occ_next_s;
      inflight_r <= read_s;
      drop_r     <= flush & inflight_r;
      words_r    <= words_r + {{(COUNT_WIDTH-1){1'b0}}, pop_s};
    end
  end

  // Buffer payload; contents are meaningless while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    b0_r <= b0_next_s;
    b1_r <= b1_next_s;
  end

  assign fifo_read = read_s;
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = b0_r;
  assign words_out = words_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-based
// model of the FIFO plus the stream of words owed downstream.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_read_data = 8'h00;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_read;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] words_out;
  logic        fifo_read_w4;
  logic [7:0]  out_data_w4;
  logic        out_valid_w4;
  logic [3:0]  words_out_w4;

  fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_read(fifo_read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .words_out(words_out));

  fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_w4 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_read(fifo_read_w4), .out_data(out_data_w4), .out_valid(out_valid_w4),
    .out_ready(out_ready), .flush(flush), .words_out(words_out_w4));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int avail; } owed_t;

  logic [7:0] fq[$];
  owed_t      ex[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         words = 0;
  int         nread = 0;
  int         first_rd = -1;
  int         checks = 0;
  int         failures = 0;

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
    nread = 0;
    first_rd = -1;
  endtask

  task automatic load(input int n, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) fq.push_back(8'($urandom_range(0, 255)));
      else     fq.push_back(8'(base + i));
    end
  endtask

  // One clock: drive, compare against the model, then advance the model.
  task automatic tick(input logic rst_v, input logic fl_v, input logic rdy_v);
    logic       val_e, pop_e, rd_e;
    logic [7:0] d;
    reset = rst_v;
    flush = fl_v;
    out_ready = rdy_v;
    fifo_empty = (fq.size() == 0);
    #1;
    val_e = (ex.size() > 0) && (ex[0].avail <= cyc);
    pop_e = val_e && rdy_v;
    rd_e  = !rst_v && !fl_v && (fq.size() > 0) &&
            ((ex.size() - (pop_e ? 1 : 0)) < 2);
    cmp("out_valid", int'(out_valid), int'(val_e));
    cmp("fifo_read", int'(fifo_read), int'(rd_e));
    cmp("words_out", int'(words_out), words % 65536);
    cmp("words_out_w4", int'(words_out_w4), words % 16);
    if (val_e) begin
      cmp("out_data", int'(out_data), int'(ex[0].d));
      cmp("out_data_w4", int'(out_data_w4), int'(ex[0].d));
    end
    if (pop_e) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (rd_e) begin
      nread++;
      if (first_rd < 0) first_rd = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_v) begin
      ex.delete();
      fq.delete();
      words = 0;
    end else begin
      if (pop_e) begin
        void'(ex.pop_front());
        words++;
      end
      if (fl_v) ex.delete();
      if (rd_e) begin
        d = fq.pop_front();
        fifo_read_data = d;
        ex.push_back('{d, cyc + 1});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    // 1: five preloaded words, consumer always ready
    clear_log();
    load(5, 1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1);
    cmp("t1_reads", nread, 5);
    cmp("t1_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) begin
      cmp("t1_data", int'(got[i]), i + 1);
      cmp("t1_gapless", got_cyc[i], first_rd + 2 + i);
    end
    cmp("t1_words", int'(words_out), 5);
    cmp("t1_idle_valid", int'(out_valid), 0);

    // 2: backpressure holds two words, then full-rate drain
    tick(1'b1, 1'b0, 1'b0);
    clear_log();
    load(10, 1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0);
    cmp("t2_reads_held", nread, 2);
    cmp("t2_valid_held", int'(out_valid), 1);
    cmp("t2_data_held", int'(out_data), 1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1);
    cmp("t2_count", got.size(), 10);
    for (int i = 0; i < got.size() && i < 10; i++) begin
      cmp("t2_data", int'(got[i]), i + 1);
      cmp("t2_gapless", got_cyc[i], got_cyc[0] + i);
    end
    cmp("t2_words", int'(words_out), 10);

    // 3: empty FIFO, consumer toggling
    tick(1'b1, 1'b0, 1'b0);
    clear_log();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'(i % 2));
    cmp("t3_reads", nread, 0);
    cmp("t3_valid", int'(out_valid), 0);
    cmp("t3_words", int'(words_out), 0);

    // 4: flush while a read is in flight
    tick(1'b1, 1'b0, 1'b0);
    clear_log();
    load(8, 1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    cmp("t4_valid_after_flush", int'(out_valid), 0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1);
    cmp("t4_count", got.size(), 6);
    if (got.size() > 0) cmp("t4_first_after_flush", int'(got[0]), 3);
    else cmp("t4_first_after_flush", -1, 3);

    // 5: reset with a full buffer, then refill
    tick(1'b1, 1'b0, 1'b0);
    clear_log();
    load(4, 1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    cmp("t5_valid", int'(out_valid), 0);
    cmp("t5_read", int'(fifo_read), 0);
    cmp("t5_words", int'(words_out), 0);
    clear_log();
    load(2, 7, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1);
    cmp("t5_count", got.size(), 2);
    if (got.size() == 2) begin
      cmp("t5_data0", int'(got[0]), 7);
      cmp("t5_data1", int'(got[1]), 8);
    end

    // 6: counter wrap on the narrow instance
    tick(1'b1, 1'b0, 1'b0);
    clear_log();
    load(18, 0, 1'b1);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b1);
    cmp("t6_count", got.size(), 18);
    cmp("t6_words_w4", int'(words_out_w4), 2);
    cmp("t6_words", int'(words_out), 18);

    // random traffic, backpressure, flushes and resets
    for (int i = 0; i < 1500; i++) begin
      if (fq.size() < 12 && $urandom_range(0, 2) == 0) load($urandom_range(1, 3), 0, 1'b1);
      tick(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
